mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and `wb_stage`. It holds one instruction, waits for the data-SRAM response of a load or store the execute stage already issued, and extracts and sign/zero-extends load data. It forwards the exception/CP0 fields unchanged in the 126-bit layout `wb_stage` consumes, and discards responses that belong to instructions killed by a WB flush.

---
 rtl/mem_stage_if.sv | 50 +++++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Bundles every handshake and data signal that the memory-access stage exchanges
// with the execute stage, the write-back stage and the data SRAM.
//
// The slave modport is the stage itself. The master modport is its surroundings:
// the execute stage, the write-back stage and the SRAM response path.
//
// Signals (as seen by the slave):
//   flush              in   WB flush; kills the held instruction
//   es_to_ms_valid     in   execute stage offers an instruction
//   es_to_ms_bus       in   132-bit instruction fields
//   ms_allowin         out  stage accepts an instruction this cycle
//   ws_allowin         in   write-back stage accepts
//   ms_to_ws_valid     out  stage offers a completed instruction
//   ms_to_ws_bus       out  126-bit completed-instruction fields
//   data_sram_data_ok  in   one-cycle SRAM response pulse, in issue order
//   data_sram_rdata    in   SRAM response data
//   stall_ms_bus       out  {valid && |gr_we, gated gr_we, dest}
//   forward_ms_bus     out  {valid && ready_go, final result}
//   ms_exc_eret        out  held instruction carries an exception or eret
// -----------------------------------------------------------------------------
interface mem_stage_if;
    logic         flush;
    logic         es_to_ms_valid;
    logic [131:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [125:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [9:0]   stall_ms_bus;
    logic [32:0]  forward_ms_bus;
    logic         ms_exc_eret;

    modport master (
        output flush, es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus, ms_exc_eret
    );

    modport slave (
        input  flush, es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus, ms_exc_eret
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage. It holds one instruction and waits for the
// data-SRAM response of a load or store that the execute stage already issued.
// It extracts and extends load data, and passes the exception/CP0 fields through
// unchanged to write-back. Responses that belong to instructions killed by a WB
// flush are counted and dropped.
//
// Ports:
//   clk     sole clock, rising edge
//   resetn  asynchronous active-low reset
//   ms_if   mem_stage_if.slave (see mem_stage_if.sv for the signal list)
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  ms_if
);
    localparam int ES_TO_MS_BUS_WD = 132;

    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    logic                       r_ms_valid;
    logic [31:0]                r_rbuf;
    logic                       r_rbuf_valid;
    logic [1:0]                 r_discard_cnt;

    logic [2:0]  w_load_type;
    logic        w_mem_req;
    logic [1:0]  w_addr_low;
    logic [3:0]  w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_pc;
    logic        w_resp_live;
    logic        w_resp_drop;
    logic        w_owner;
    logic        w_ready_go;
    logic        w_allowin;
    logic        w_to_ws_valid;
    logic        w_leave;
    logic [31:0] w_ld;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_result;

    assign w_load_type  = r_bus[78:76];
    assign w_mem_req    = r_bus[75];
    assign w_addr_low   = r_bus[74:73];
    assign w_gr_we      = r_bus[72:69];
    assign w_dest       = r_bus[68:64];
    assign w_alu_result = r_bus[63:32];
    assign w_pc         = r_bus[31:0];

    // A response belongs to the held instruction only when no killed
    // instruction still has a response in flight ahead of it.
    assign w_resp_live   = ms_if.data_sram_data_ok && (r_discard_cnt == 2'd0);
    assign w_resp_drop   = ms_if.data_sram_data_ok && (r_discard_cnt != 2'd0);
    assign w_owner       = r_ms_valid && w_mem_req && !r_rbuf_valid;
    assign w_ready_go    = !w_mem_req || r_rbuf_valid || w_resp_live;
    assign w_allowin     = !r_ms_valid || (w_ready_go && ms_if.ws_allowin);
    assign w_to_ws_valid = r_ms_valid && w_ready_go;
    assign w_leave       = w_to_ws_valid && ms_if.ws_allowin;

    // A buffered response takes precedence over the live SRAM data, so a load
    // that caught its data while WB was stalled delivers it later.
    assign w_ld = r_rbuf_valid ? r_rbuf : ms_if.data_sram_rdata;

    // Pick the addressed byte/halfword, then extend it by load type.
    // Load types 110/111 behave like a plain ALU result.
    always_comb begin
        w_byte = w_ld[7:0];
        case (w_addr_low)
            2'd0: w_byte = w_ld[7:0];
            2'd1: w_byte = w_ld[15:8];
            2'd2: w_byte = w_ld[23:16];
            2'd3: w_byte = w_ld[31:24];
            default: w_byte = w_ld[7:0];
        endcase
        w_half   = w_addr_low[1] ? w_ld[31:16] : w_ld[15:0];
        w_result = w_alu_result;
        case (w_load_type)
            3'b001:  w_result = {{24{w_byte[7]}}, w_byte};
            3'b010:  w_result = {24'h0, w_byte};
            3'b011:  w_result = {{16{w_half[15]}}, w_half};
            3'b100:  w_result = {16'h0, w_half};
            3'b101:  w_result = w_ld;
            default: w_result = w_alu_result;
        endcase
    end

    // Instruction register. A flush wins over a new instruction offered in the
    // same cycle. The bus register may load while flushing, but it stays invalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid <= 1'b0;
            r_bus      <= '0;
        end else begin
            if (ms_if.flush) begin
                r_ms_valid <= 1'b0;
            end else if (w_allowin) begin
                r_ms_valid <= ms_if.es_to_ms_valid;
            end
            if (ms_if.es_to_ms_valid && w_allowin) begin
                r_bus <= ms_if.es_to_ms_bus;
            end
        end
    end

    // Response buffer. It is only filled when write-back cannot take the
    // instruction in the same cycle. Leaving or flushing empties it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rbuf       <= 32'h0;
            r_rbuf_valid <= 1'b0;
        end else if (ms_if.flush || w_leave) begin
            r_rbuf_valid <= 1'b0;
        end else if (w_resp_live && w_owner) begin
            r_rbuf       <= ms_if.data_sram_rdata;
            r_rbuf_valid <= 1'b1;
        end
    end

    // Count responses still owed to killed instructions. A response arriving in
    // the flush cycle satisfies the killed request itself, so nothing is added.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_discard_cnt <= 2'd0;
        end else if (w_resp_drop) begin
            r_discard_cnt <= r_discard_cnt - 2'd1;
        end else if (ms_if.flush && w_owner && !ms_if.data_sram_data_ok
                     && (r_discard_cnt != 2'd3)) begin
            r_discard_cnt <= r_discard_cnt + 2'd1;
        end
    end

    assign ms_if.ms_allowin     = w_allowin;
    assign ms_if.ms_to_ws_valid = w_to_ws_valid;
    assign ms_if.ms_to_ws_bus   = {r_bus[131:79], w_gr_we, w_dest, w_result, w_pc};
    assign ms_if.stall_ms_bus   = {r_ms_valid && (|w_gr_we), {4{r_ms_valid}} & w_gr_we, w_dest};
    assign ms_if.forward_ms_bus = {r_ms_valid && w_ready_go, w_result};
    assign ms_if.ms_exc_eret    = r_ms_valid && (r_bus[98] || r_bus[89]);
endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Bench for mem_stage. Directed scenarios cover latency, buffering, flush and
// discard handling, pass-through fields and asynchronous reset. A randomized
// phase then issues instructions and SRAM responses. Expected results come from
// an arithmetic model of load extraction. They are queued at issue time and
// compared by an independent monitor whenever an instruction leaves the stage.
// -----------------------------------------------------------------------------
module tb_mem_stage;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    mem_stage_if ifc ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .ms_if  (ifc)
    );

    typedef struct {
        int           id;
        logic [125:0] bus;
    } sbEntry_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        bit          killed;
    } memEntry_t;

    int        checks = 0;
    int        errors = 0;
    bit        rndPhase = 1'b0;
    sbEntry_t  sbQ[$];
    memEntry_t memQ[$];

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge. Then let the
    // combinational outputs settle.
    task automatic applyStimulus(input logic esv, input logic [131:0] b, input logic ws,
                                 input logic fl, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        ifc.es_to_ms_valid    = esv;
        ifc.es_to_ms_bus      = b;
        ifc.ws_allowin        = ws;
        ifc.flush             = fl;
        ifc.data_sram_data_ok = dok;
        ifc.data_sram_rdata   = rd;
        #3;
    endtask

    // Load result from the ISA meaning of each load type, using shifts, masks
    // and two's-complement arithmetic.
    function automatic logic [31:0] refResult(input logic [131:0] b, input logic [31:0] data);
        int unsigned lane;
        logic [31:0] v;
        lane = 32'(b[74:73]);
        case (b[78:76])
            3'd1: begin
                v = (data >> (8 * lane)) & 32'hFF;
                if (v >= 32'h80) v = v - 32'h100;
            end
            3'd2: v = (data >> (8 * lane)) & 32'hFF;
            3'd3: begin
                v = (data >> (16 * (lane / 2))) & 32'hFFFF;
                if (v >= 32'h8000) v = v - 32'h10000;
            end
            3'd4: v = (data >> (16 * (lane / 2))) & 32'hFFFF;
            3'd5: v = data;
            default: v = b[63:32];
        endcase
        return v;
    endfunction

    function automatic logic [125:0] refBus(input logic [131:0] b, input logic [31:0] data);
        return {b[131:79], b[72:69], b[68:64], refResult(b, data), b[31:0]};
    endfunction

    function automatic logic [131:0] mkInstr(input logic [2:0] lt, input logic mr,
                                             input logic [1:0] al);
        return {32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0,
                lt, mr, al, 4'h1, 5'd3, 32'hA5A5A5A5, 32'hBFC00100};
    endfunction

    // Monitor: every instruction handed to WB must match the oldest live expectation.
    initial begin : monitor
        sbEntry_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rndPhase && resetn && ifc.ms_to_ws_valid && ifc.ws_allowin) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %h required none", ifc.ms_to_ws_bus);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("ms_to_ws_bus", 128'(ifc.ms_to_ws_bus), 128'(e.bus));
                    checkOutput("forward_ms_bus", 128'(ifc.forward_ms_bus), 128'({1'b1, e.bus[63:32]}));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [131:0] b;
        logic [131:0] rb;
        logic [31:0]  rd;
        bit           esv, ws, fl, dok, headKilled, accept;
        int           heldId, nextId, killedCnt, waitCycles;
        memEntry_t    me;

        ifc.es_to_ms_valid    = 1'b0;
        ifc.es_to_ms_bus      = '0;
        ifc.ws_allowin        = 1'b1;
        ifc.flush             = 1'b0;
        ifc.data_sram_data_ok = 1'b0;
        ifc.data_sram_rdata   = 32'h0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Reset state
        applyStimulus(0, '0, 1, 0, 0, 32'h0);
        checkOutput("rst_allowin", 128'(ifc.ms_allowin), 128'(1));
        checkOutput("rst_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
        checkOutput("rst_exc_eret", 128'(ifc.ms_exc_eret), 128'(0));
        checkOutput("rst_stall_hi", 128'(ifc.stall_ms_bus[9:5]), 128'(0));
        checkOutput("rst_fwd_valid", 128'(ifc.forward_ms_bus[32]), 128'(0));

        // lb from byte lane 3, response 3 cycles after entry
        applyStimulus(1, mkInstr(3'd1, 1'b1, 2'd3), 1, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, '0, 1, 0, 0, 32'h0);
            checkOutput("lb_wait_allowin", 128'(ifc.ms_allowin), 128'(0));
            checkOutput("lb_wait_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
        end
        applyStimulus(0, '0, 1, 0, 1, 32'h80123456);
        checkOutput("lb_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
        checkOutput("lb_result", 128'(ifc.ms_to_ws_bus[63:32]), 128'(32'hFFFFFF80));

        // lhu whose response arrives while WB stalls
        applyStimulus(1, mkInstr(3'd4, 1'b1, 2'd2), 1, 0, 0, 32'h0);
        applyStimulus(0, '0, 0, 0, 1, 32'hBEEF0000);
        checkOutput("lhu_stall_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
        checkOutput("lhu_stall_allowin", 128'(ifc.ms_allowin), 128'(0));
        applyStimulus(0, '0, 0, 0, 0, 32'h0);
        checkOutput("lhu_held_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
        applyStimulus(0, '0, 1, 0, 0, 32'h12345678);
        checkOutput("lhu_result", 128'(ifc.ms_to_ws_bus[63:32]), 128'(32'h0000BEEF));

        // Flush a pending load; its late response must be discarded
        applyStimulus(1, mkInstr(3'd5, 1'b1, 2'd0), 1, 0, 0, 32'h0);
        applyStimulus(0, '0, 1, 1, 0, 32'h0);
        applyStimulus(1, mkInstr(3'd5, 1'b1, 2'd0), 1, 0, 0, 32'h0);
        checkOutput("flush_allowin", 128'(ifc.ms_allowin), 128'(1));
        applyStimulus(0, '0, 1, 0, 1, 32'h11111111);
        checkOutput("discard_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
        applyStimulus(0, '0, 1, 0, 1, 32'h22222222);
        checkOutput("after_discard_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
        checkOutput("after_discard_result", 128'(ifc.ms_to_ws_bus[63:32]), 128'(32'h22222222));

        // Flush coincident with the held load's own response: nothing to discard
        applyStimulus(1, mkInstr(3'd5, 1'b1, 2'd0), 1, 0, 0, 32'h0);
        applyStimulus(0, '0, 1, 1, 1, 32'h55555555);
        applyStimulus(1, mkInstr(3'd5, 1'b1, 2'd0), 1, 0, 0, 32'h0);
        applyStimulus(0, '0, 1, 0, 1, 32'h33333333);
        checkOutput("coinc_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
        checkOutput("coinc_result", 128'(ifc.ms_to_ws_bus[63:32]), 128'(32'h33333333));

        // ALU instruction carrying an exception
        b = mkInstr(3'd0, 1'b0, 2'd0);
        b[131:100] = 32'hDEADBEEF;
        b[98]      = 1'b1;
        b[97:90]   = 8'h04;
        b[72:69]   = 4'hF;
        b[68:64]   = 5'd7;
        applyStimulus(1, b, 0, 0, 0, 32'h0);
        applyStimulus(0, '0, 0, 0, 0, 32'h0);
        checkOutput("exc_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
        checkOutput("exc_eret", 128'(ifc.ms_exc_eret), 128'(1));
        checkOutput("exc_bus", 128'(ifc.ms_to_ws_bus),
                    128'({32'hDEADBEEF, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 8'h0,
                          4'hF, 5'd7, 32'hA5A5A5A5, 32'hBFC00100}));
        checkOutput("exc_stall", 128'(ifc.stall_ms_bus), 128'({1'b1, 4'hF, 5'd7}));
        applyStimulus(0, '0, 1, 0, 0, 32'h0);
        checkOutput("exc_leave_valid", 128'(ifc.ms_to_ws_valid), 128'(1));
        applyStimulus(0, '0, 1, 0, 0, 32'h0);
        checkOutput("exc_gone", 128'(ifc.ms_exc_eret), 128'(0));

        // Asynchronous reset while a buffered load waits
        applyStimulus(1, mkInstr(3'd5, 1'b1, 2'd0), 1, 0, 0, 32'h0);
        applyStimulus(0, '0, 0, 0, 1, 32'hCAFEF00D);
        applyStimulus(0, '0, 0, 0, 0, 32'h0);
        checkOutput("prerst_fwd_valid", 128'(ifc.forward_ms_bus), 128'({1'b1, 32'hCAFEF00D}));
        #1 resetn = 1'b0;
        #1;
        checkOutput("async_rst_allowin", 128'(ifc.ms_allowin), 128'(1));
        checkOutput("async_rst_valid", 128'(ifc.ms_to_ws_valid), 128'(0));
        checkOutput("async_rst_stall_hi", 128'(ifc.stall_ms_bus[9:5]), 128'(0));
        checkOutput("async_rst_fwd_valid", 128'(ifc.forward_ms_bus[32]), 128'(0));
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic against the reference model
        rndPhase = 1'b1;
        heldId   = -1;
        nextId   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rb[31:0]    = $urandom;
            rb[63:32]   = $urandom;
            rb[95:64]   = $urandom;
            rb[127:96]  = $urandom;
            rb[131:128] = 4'($urandom);
            rb[75]      = 1'($urandom % 2);
            rb[78:76]   = rb[75] ? 3'($urandom_range(0, 7)) : 3'd0;
            ws  = ($urandom % 10) < 7;
            esv = ($urandom % 10) < 6;
            dok = 1'b0;
            headKilled = 1'b0;
            rd  = $urandom;
            if (memQ.size() > 0 && ($urandom % 2) == 1) begin
                dok = 1'b1;
                rd  = memQ[0].data;
                headKilled = memQ[0].killed;
            end
            killedCnt = 0;
            foreach (memQ[k]) if (memQ[k].killed) killedCnt++;
            fl = !ws && (($urandom % 8) == 0) && !(dok && headKilled) && (killedCnt < 3);

            applyStimulus(esv, rb, ws, fl, dok, rd);

            if (dok) void'(memQ.pop_front());
            accept = esv && ifc.ms_allowin && !fl;
            if (fl) begin
                for (int k = 0; k < sbQ.size(); k++) begin
                    if (sbQ[k].id == heldId) begin
                        sbQ.delete(k);
                        break;
                    end
                end
                foreach (memQ[k]) if (memQ[k].id == heldId) memQ[k].killed = 1'b1;
                heldId = -1;
            end else if (ifc.ms_allowin) begin
                heldId = accept ? nextId : -1;
            end
            if (accept) begin
                me.id     = nextId;
                me.data   = $urandom;
                me.killed = 1'b0;
                if (rb[75]) memQ.push_back(me);
                sbQ.push_back('{nextId, refBus(rb, me.data)});
                nextId++;
            end
        end

        // Drain: answer every outstanding request and let WB take everything
        waitCycles = 0;
        while ((sbQ.size() > 0 || memQ.size() > 0) && waitCycles < 200) begin
            dok = memQ.size() > 0;
            rd  = dok ? memQ[0].data : 32'h0;
            applyStimulus(0, '0, 1, 0, dok, rd);
            if (dok) void'(memQ.pop_front());
            waitCycles++;
        end
        checkOutput("drain_done", 128'(sbQ.size() + memQ.size()), 128'(0));
        rndPhase = 1'b0;
        applyStimulus(0, '0, 1, 0, 0, 32'h0);
        checkOutput("idle_allowin", 128'(ifc.ms_allowin), 128'(1));
        checkOutput("idle_valid", 128'(ifc.ms_to_ws_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
